truth_table_probe: RTL and testbench

TRUTH_TABLE_PROBE -- requirements
Module: truth_table_probe

---
 rtl/truth_table_probe_if.sv | 24 ++
 rtl/truth_table_probe.sv | 162 ++++++++++++++++
 tb/tb_truth_table_probe.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_probe_if.sv
// Bus between a truth-table probe and the requester / function under test.
// master drives requests, dut_out and code_ready; slave is the probe itself.
interface truth_table_probe_if;
    logic       start;
    logic       dut_in1;
    logic       dut_in2;
    logic       dut_in3;
    logic       dut_out;
    logic       busy;
    logic [7:0] code;
    logic       code_valid;
    logic       code_ready;
    logic       unstable;

    modport master (
        output start, dut_out, code_ready,
        input  dut_in1, dut_in2, dut_in3, busy, code, code_valid, unstable
    );

    modport slave (
        input  start, dut_out, code_ready,
        output dut_in1, dut_in2, dut_in3, busy, code, code_valid, unstable
    );
endinterface

// File: rtl/truth_table_probe.sv
// Sweeps all 8 input rows of a 3-input function, majority-votes its output per row
// and returns the reconstructed 8-bit truth table through a valid/ready handshake.
module truth_table_probe #(
    parameter int unsigned SETTLE_CYCLES = 3,
    parameter int unsigned SAMPLES       = 3
) (
    input  logic                clk,
    input  logic                reset,
    truth_table_probe_if.slave  bus
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned ONES_W = 4;
    localparam int unsigned ROW_W  = 3;
    localparam int unsigned CODE_W = 8;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(SAMPLES - 1);
    localparam logic [ONES_W-1:0] ONES_HALF   = ONES_W'(SAMPLES / 2);
    localparam logic [ONES_W-1:0] ONES_ALL    = ONES_W'(SAMPLES);
    localparam logic [ROW_W-1:0]  ROW_LAST    = 3'd7;

    logic [1:0]        r_state,      w_state_nxt;
    logic [ROW_W-1:0]  r_row,        w_row_nxt;
    logic [CNT_W-1:0]  r_cnt,        w_cnt_nxt;
    logic [ONES_W-1:0] r_ones,       w_ones_nxt;
    logic [CODE_W-1:0] r_code,       w_code_nxt;
    logic              r_unstable,   w_unstable_nxt;
    logic              r_code_valid, w_code_valid_nxt;
    logic              r_busy,       w_busy_nxt;
    logic [ROW_W-1:0]  r_dut_in,     w_dut_in_nxt;
    logic [1:0]        r_rst_sync;

    logic              w_start;
    logic [ONES_W-1:0] w_ones_tot;

    // Start is blocked until reset release has passed through two flops.
    assign w_start    = bus.start & ~r_rst_sync[1];
    assign w_ones_tot = r_ones + ONES_W'(bus.dut_out);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rst_sync <= 2'b11;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_row        <= '0;
            r_cnt        <= '0;
            r_ones       <= '0;
            r_code       <= '0;
            r_unstable   <= 1'b0;
            r_code_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_dut_in     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_row        <= w_row_nxt;
            r_cnt        <= w_cnt_nxt;
            r_ones       <= w_ones_nxt;
            r_code       <= w_code_nxt;
            r_unstable   <= w_unstable_nxt;
            r_code_valid <= w_code_valid_nxt;
            r_busy       <= w_busy_nxt;
            r_dut_in     <= w_dut_in_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_row_nxt        = r_row;
        w_cnt_nxt        = r_cnt;
        w_ones_nxt       = r_ones;
        w_code_nxt       = r_code;
        w_unstable_nxt   = r_unstable;
        w_code_valid_nxt = r_code_valid;
        w_busy_nxt       = r_busy;

        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt    = S_SETTLE;
                    w_row_nxt      = '0;
                    w_cnt_nxt      = '0;
                    w_ones_nxt     = '0;
                    w_code_nxt     = '0;
                    w_unstable_nxt = 1'b0;
                    w_busy_nxt     = 1'b1;
                end
            end
            S_SETTLE: begin
                if (r_cnt == SETTLE_LAST) begin
                    w_state_nxt = S_SAMPLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_SAMPLE: begin
                w_ones_nxt = w_ones_tot;
                if (r_cnt == SAMPLE_LAST) begin
                    w_code_nxt[3'd7 - r_row] = (w_ones_tot > ONES_HALF);
                    if ((w_ones_tot != '0) && (w_ones_tot != ONES_ALL)) begin
                        w_unstable_nxt = 1'b1;
                    end
                    w_ones_nxt = '0;
                    w_cnt_nxt  = '0;
                    if (r_row == ROW_LAST) begin
                        w_state_nxt      = S_HOLD;
                        w_code_valid_nxt = 1'b1;
                        w_busy_nxt       = 1'b0;
                    end else begin
                        w_row_nxt   = r_row + 3'd1;
                        w_state_nxt = S_SETTLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_HOLD: begin
                // Handshake and a new request on the same edge chain without an IDLE cycle.
                if (bus.code_ready) begin
                    w_code_valid_nxt = 1'b0;
                    if (w_start) begin
                        w_state_nxt    = S_SETTLE;
                        w_row_nxt      = '0;
                        w_cnt_nxt      = '0;
                        w_ones_nxt     = '0;
                        w_code_nxt     = '0;
                        w_unstable_nxt = 1'b0;
                        w_busy_nxt     = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_dut_in_nxt = ((w_state_nxt == S_SETTLE) || (w_state_nxt == S_SAMPLE)) ? w_row_nxt : '0;
    end

    assign bus.dut_in1    = r_dut_in[2];
    assign bus.dut_in2    = r_dut_in[1];
    assign bus.dut_in3    = r_dut_in[0];
    assign bus.busy       = r_busy;
    assign bus.code       = r_code;
    assign bus.code_valid = r_code_valid;
    assign bus.unstable   = r_unstable;

endmodule

// File: tb/tb_truth_table_probe.sv
// Directed bench for truth_table_probe: default instance probes a modelled rule,
// a SETTLE_CYCLES=1/SAMPLES=1 instance probes constant functions.
module tb_truth_table_probe;

    logic clk = 1'b0;
    logic reset;

    truth_table_probe_if ifa ();
    truth_table_probe_if ifb ();

    logic [7:0] rule_a;
    logic       glitch_a;
    logic       const_b;
    logic [2:0] row_a;

    int n_pass;
    int n_total;
    int rises;
    logic prev_valid;

    always #5 clk = ~clk;

    assign row_a       = {ifa.dut_in1, ifa.dut_in2, ifa.dut_in3};
    assign ifa.dut_out = rule_a[3'd7 - row_a] ^ glitch_a;
    assign ifb.dut_out = const_b;

    truth_table_probe u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    truth_table_probe #(.SETTLE_CYCLES(1), .SAMPLES(1)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    // Counts code_valid rising edges on instance A.
    always @(posedge clk) begin
        prev_valid <= ifa.code_valid;
        if (ifa.code_valid && !prev_valid) rises <= rises + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives the modelled function until code_valid; lat = edges since accept or -1.
    task automatic wait_valid_a(input bit inv, input bit poke, output int lat);
        int k;
        k   = 0;
        lat = -1;
        while (!ifa.code_valid && k < 200) begin
            glitch_a  = inv && ((k % 6) == 3);
            ifa.start = poke && ((k % 10) == 5);
            tick();
            k++;
        end
        ifa.start = 1'b0;
        glitch_a  = 1'b0;
        if (ifa.code_valid) lat = k;
    endtask

    task automatic run_sweep_a(input bit inv, input bit poke, output int lat);
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        wait_valid_a(inv, poke, lat);
    endtask

    task automatic release_a;
        ifa.code_ready = 1'b1;
        tick();
        ifa.code_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #1;
        n_total++;
        if ({ifa.busy, ifa.code_valid, ifa.unstable, row_a, ifa.code} !== 14'h0) begin
            $display("FAIL reset_outputs: got %h expected 0",
                     {ifa.busy, ifa.code_valid, ifa.unstable, row_a, ifa.code});
        end else n_pass++;
        tick();
        reset = 1'b0;
        repeat (4) tick();
        n_total++;
        if ({ifb.busy, ifb.code_valid, ifb.code} !== 10'h0) begin
            $display("FAIL reset_b_idle: got %h expected 0", {ifb.busy, ifb.code_valid, ifb.code});
        end else n_pass++;
    endtask

    task automatic test_rule51;
        int lat;
        rule_a    = 8'h51;
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        n_total++;
        if (ifa.busy !== 1'b1) $display("FAIL rule51_busy: got %b expected 1", ifa.busy);
        else n_pass++;
        wait_valid_a(1'b0, 1'b0, lat);
        n_total++;
        if (lat != 48) $display("FAIL rule51_latency: got %0d expected 48", lat);
        else n_pass++;
        n_total++;
        if ({ifa.code, ifa.unstable, ifa.busy} !== {8'h51, 1'b0, 1'b0})
            $display("FAIL rule51_result: got code=%h unstable=%b busy=%b expected code=51 unstable=0 busy=0",
                     ifa.code, ifa.unstable, ifa.busy);
        else n_pass++;
    endtask

    task automatic test_hold;
        int lat;
        for (int i = 0; i < 10; i++) begin
            ifa.start = (i % 3 == 1);
            tick();
            n_total++;
            if ({ifa.code_valid, ifa.unstable, ifa.busy, ifa.code} !== {3'b100, 8'h51})
                $display("FAIL hold_stable_%0d: got %h expected %h", i,
                         {ifa.code_valid, ifa.unstable, ifa.busy, ifa.code}, {3'b100, 8'h51});
            else n_pass++;
        end
        ifa.start = 1'b0;
        release_a();
        n_total++;
        if ({ifa.code_valid, ifa.busy, ifa.code} !== {2'b00, 8'h51})
            $display("FAIL hold_release: got %h expected %h", {ifa.code_valid, ifa.busy, ifa.code}, {2'b00, 8'h51});
        else n_pass++;
        run_sweep_a(1'b0, 1'b0, lat);
        ifa.code_ready = 1'b1;
        ifa.start      = 1'b1;
        tick();
        ifa.code_ready = 1'b0;
        ifa.start      = 1'b0;
        n_total++;
        if ({ifa.busy, ifa.code_valid, row_a, ifa.code} !== {2'b10, 3'b000, 8'h00})
            $display("FAIL hold_chain_accept: got %h expected %h",
                     {ifa.busy, ifa.code_valid, row_a, ifa.code}, {2'b10, 3'b000, 8'h00});
        else n_pass++;
        wait_valid_a(1'b0, 1'b0, lat);
        n_total++;
        if (lat != 48 || ifa.code !== 8'h51)
            $display("FAIL hold_chain_sweep: got lat=%0d code=%h expected lat=48 code=51", lat, ifa.code);
        else n_pass++;
        release_a();
    endtask

    task automatic test_glitch;
        int lat;
        run_sweep_a(1'b1, 1'b0, lat);
        n_total++;
        if (lat != 48 || {ifa.code, ifa.unstable} !== {8'h51, 1'b1})
            $display("FAIL glitch_result: got lat=%0d code=%h unstable=%b expected lat=48 code=51 unstable=1",
                     lat, ifa.code, ifa.unstable);
        else n_pass++;
        release_a();
        n_total++;
        if (ifa.unstable !== 1'b1) $display("FAIL glitch_retained: got %b expected 1", ifa.unstable);
        else n_pass++;
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        n_total++;
        if (ifa.unstable !== 1'b0) $display("FAIL glitch_clear_on_accept: got %b expected 0", ifa.unstable);
        else n_pass++;
        wait_valid_a(1'b0, 1'b0, lat);
        release_a();
    endtask

    task automatic test_const;
        int k;
        for (int v = 0; v < 2; v++) begin
            const_b   = (v == 0);
            ifb.start = 1'b1;
            tick();
            ifb.start = 1'b0;
            k = 0;
            while (!ifb.code_valid && k < 100) begin
                tick();
                k++;
            end
            n_total++;
            if (!ifb.code_valid || k != 16)
                $display("FAIL const%0d_latency: got %0d expected 16", const_b, k);
            else n_pass++;
            n_total++;
            if ({ifb.code, ifb.unstable} !== {(v == 0) ? 8'hFF : 8'h00, 1'b0})
                $display("FAIL const%0d_code: got %h expected %h", const_b, ifb.code, (v == 0) ? 8'hFF : 8'h00);
            else n_pass++;
            ifb.code_ready = 1'b1;
            tick();
            ifb.code_ready = 1'b0;
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        repeat (26) tick();
        n_total++;
        if (row_a !== 3'b100) $display("FAIL reset_mid_row: got %b expected 100", row_a);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_total++;
        if ({ifa.busy, ifa.code_valid, ifa.unstable, row_a, ifa.code} !== 14'h0)
            $display("FAIL reset_mid_async: got %h expected 0",
                     {ifa.busy, ifa.code_valid, ifa.unstable, row_a, ifa.code});
        else n_pass++;
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();
        run_sweep_a(1'b0, 1'b0, lat);
        n_total++;
        if (lat != 48 || ifa.code !== 8'h51)
            $display("FAIL reset_mid_resweep: got lat=%0d code=%h expected lat=48 code=51", lat, ifa.code);
        else n_pass++;
        release_a();
    endtask

    task automatic test_back_to_back;
        int lat;
        int base;
        base = rises;
        run_sweep_a(1'b0, 1'b1, lat);
        n_total++;
        if (lat != 48 || ifa.code !== 8'h51)
            $display("FAIL busy_start_sweep: got lat=%0d code=%h expected lat=48 code=51", lat, ifa.code);
        else n_pass++;
        release_a();
        repeat (60) tick();
        n_total++;
        if (rises - base != 1 || ifa.busy !== 1'b0)
            $display("FAIL busy_start_ignored: got valids=%0d busy=%b expected valids=1 busy=0",
                     rises - base, ifa.busy);
        else n_pass++;
    endtask

    initial begin
        n_pass         = 0;
        n_total        = 0;
        rises          = 0;
        rule_a         = 8'h51;
        glitch_a       = 1'b0;
        const_b        = 1'b0;
        ifa.start      = 1'b0;
        ifa.code_ready = 1'b0;
        ifb.start      = 1'b0;
        ifb.code_ready = 1'b0;
        test_reset();
        test_rule51();
        test_hold();
        test_glitch();
        test_const();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
